// File: rtl/fft_sink_feeder.sv
`default_nettype none
// ============================================================================
// fft_sink_feeder: frames offset-binary ADC samples and streams them to the
// FFT Avalon-ST sink. Optional drop counter: FEEDER_DROP_CNT_EN. Rev 1.0
// ============================================================================
module fft_sink_feeder #(
  parameter int FFT_N  = 1024,
  parameter int ADC_W  = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              fft_en,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [15:0]       sink_real,
  output logic [15:0]       sink_imag,
  output logic [1:0]        sink_error,
`ifdef FEEDER_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_N - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     sink_valid_q, sink_valid_d;
  logic                     busy_q;
  logic [15:0]              ram_q;
  logic [15:0]              mem [FFT_N];
  logic signed [ADC_W-1:0]  conv_s;
  logic [15:0]              conv;
  logic                     wr_en, rd_en, xfer;

  // Flipping the MSB turns offset-binary into two's complement; the cast sign-extends.
  assign conv_s = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
  assign conv   = 16'(conv_s);

  assign xfer    = sink_valid_q && sink_ready;
  assign rd_en   = (state_q == S_LOAD) || (state_q == S_SEND);
  // Re-reading the current address during a stall keeps sink_real stable.
  assign rd_addr = xfer ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sink_valid_d = sink_valid_q;
    wr_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (fft_en) state_d = S_FILL;
      end
      S_FILL: begin
        if (!fft_en) begin
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else if (adc_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == LAST_ADDR) state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        sink_valid_d = 1'b1;
        if (xfer) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          if (rd_ptr_q == LAST_ADDR) begin
            sink_valid_d = 1'b0;
            state_d      = fft_en ? S_FILL : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sink_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ram_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sink_valid_q <= sink_valid_d;
      busy_q       <= (state_d == S_LOAD) || (state_d == S_SEND);
      if (rd_en) ram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr_en) mem[wr_ptr_q] <= conv;
  end

`ifdef FEEDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (adc_valid && rd_en && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign sink_valid = sink_valid_q;
  assign sink_sop   = sink_valid_q && (rd_ptr_q == '0);
  assign sink_eop   = sink_valid_q && (rd_ptr_q == LAST_ADDR);
  assign sink_real  = ram_q;
  assign sink_imag  = 16'h0000;
  assign sink_error = 2'b00;
  assign busy       = busy_q;

endmodule
`default_nettype wire
